// File: rtl/axi4l_master_pkg.sv
// Shared widths, response codes and FSM encoding
// for the single-outstanding AXI4-Lite master.
package axi4l_master_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;
  localparam int StrbW      = MemBus / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

endpackage

// File: rtl/axi4l_master.sv
// Core request port to AXI4-Lite bridge, one transaction in flight.
// Ports: clk/rst_n, req/we/addr/wdata/wstrb in, ready/done/rdata/err out, AXI4-Lite master.
module axi4l_master
  import axi4l_master_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [MemAddrBus-1:0] addr_i,
  input  logic [MemBus-1:0]     wdata_i,
  input  logic [StrbW-1:0]      wstrb_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [MemBus-1:0]     rdata_o,
  output logic                  err_o,
  output logic [MemAddrBus-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [MemBus-1:0]     m_axi_wdata,
  output logic [StrbW-1:0]      m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [MemAddrBus-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [MemBus-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_e                state_q, state_d;
  logic [MemAddrBus-1:0] addr_q, addr_d;
  logic [MemBus-1:0]     wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [MemBus-1:0]     rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          if (we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      ST_WADDR: begin
        // AW and W retire independently; move on once both are gone
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (m_axi_bvalid) begin
          err_d   = (m_axi_bresp != RESP_OKAY);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = (m_axi_rresp != RESP_OKAY);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ready_o       = (state_q == ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == ST_WRESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axi4l_master.sv
// Bench for axi4l_master: delay-configurable slave model,
// scoreboard queue and a memory reference model.
module tb_axi4l_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        ready_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  axi4l_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .ready_o(ready_o), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, ar_got;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  logic [31:0] smem [16];

  function automatic logic [1:0] resp_of(logic [31:0] a);
    if (a[31:28] == 4'hE) return 2'b10;
    if (a[31:28] == 4'hD) return 2'b11;
    return 2'b00;
  endfunction

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);

  wire aw_hs = m_axi_awvalid && m_axi_awready;
  wire w_hs  = m_axi_wvalid && m_axi_wready;
  wire ar_hs = m_axi_arvalid && m_axi_arready;
  wire [31:0] cur_aw = aw_got ? aw_a : m_axi_awaddr;
  wire [31:0] cur_wd = w_got ? w_d : m_axi_wdata;
  wire [3:0]  cur_ws = w_got ? w_s : m_axi_wstrb;
  wire [31:0] cur_ar = ar_got ? ar_a : m_axi_araddr;
  wire aw_have = aw_got || aw_hs;
  wire w_have  = w_got || w_hs;
  wire ar_have = ar_got || ar_hs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0; ar_a <= '0;
      m_axi_bvalid <= 0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
      end else if (aw_have && w_have && !m_axi_bvalid) begin
        if (b_cnt >= b_dly) begin
          m_axi_bvalid <= 1'b1;
          m_axi_bresp  <= resp_of(cur_aw);
          if (resp_of(cur_aw) == 2'b00)
            for (int i = 0; i < 4; i++)
              if (cur_ws[i]) smem[cur_aw[5:2]][i*8 +: 8] <= cur_wd[i*8 +: 8];
          aw_got <= 0; w_got <= 0; b_cnt <= 0;
        end else begin
          b_cnt <= b_cnt + 1;
          aw_got <= 1; w_got <= 1;
          aw_a <= cur_aw; w_d <= cur_wd; w_s <= cur_ws;
        end
      end else begin
        if (aw_hs) begin aw_got <= 1; aw_a <= m_axi_awaddr; end
        if (w_hs) begin w_got <= 1; w_d <= m_axi_wdata; w_s <= m_axi_wstrb; end
      end
      if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end else if (ar_have && !m_axi_rvalid) begin
        if (r_cnt >= r_dly) begin
          m_axi_rvalid <= 1'b1;
          m_axi_rresp  <= resp_of(cur_ar);
          m_axi_rdata  <= (resp_of(cur_ar) == 2'b00) ? smem[cur_ar[5:2]] : 32'h0;
          ar_got <= 0; r_cnt <= 0;
        end else begin
          r_cnt <= r_cnt + 1;
          ar_got <= 1; ar_a <= cur_ar;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd = '0;

  function automatic bit is_err(logic [31:0] a);
    return (a[31:28] == 4'hE) || (a[31:28] == 4'hD);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      exp_t e;
      logic [31:0] xr;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got done_o=1 expected no pending txn (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("err", {31'd0, err_o}, {31'd0, is_err(e.addr)});
        chk("latency", cyc - e.acc, e.lat);
        if (e.we) begin
          chk("rdata_hold", rdata_o, last_rd);
          if (!is_err(e.addr))
            for (int i = 0; i < 4; i++)
              if (e.strb[i]) ref_mem[e.addr[5:2]][i*8 +: 8] = e.data[i*8 +: 8];
        end else begin
          xr = is_err(e.addr) ? 32'h0 : ref_mem[e.addr[5:2]];
          chk("rdata", rdata_o, xr);
          last_rd = xr;
        end
      end
    end
  end

  // Valids and their payload must stay put until handshaked
  logic        p_aw, p_w, p_ar;
  logic [31:0] p_awa, p_wd, p_ara;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_aw = 0; p_w = 0; p_ar = 0;
    end else begin
      if (p_aw) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr[30:0]}, {1'b1, p_awa[30:0]});
      if (p_w) chk("w_hold", {m_axi_wvalid, m_axi_wdata[30:0]}, {1'b1, p_wd[30:0]});
      if (p_ar) chk("ar_hold", {m_axi_arvalid, m_axi_araddr[30:0]}, {1'b1, p_ara[30:0]});
      p_aw = m_axi_awvalid && !m_axi_awready; p_awa = m_axi_awaddr;
      p_w  = m_axi_wvalid && !m_axi_wready;   p_wd  = m_axi_wdata;
      p_ar = m_axi_arvalid && !m_axi_arready; p_ara = m_axi_araddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_dly(int aw, int w, int b, int ar, int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  function automatic int wlat();
    return ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
  endfunction

  function automatic int rlat();
    return ar_dly + r_dly + 3;
  endfunction

  task automatic issue(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_i = 1; we_i = we; addr_i = a; wdata_i = d; wstrb_i = s;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready_o=0 expected 1 (cycle %0d)", cyc);
      req_i = 0;
      return;
    end
    e.we = we; e.addr = a; e.data = d; e.strb = s;
    e.acc = cyc; e.lat = we ? wlat() : rlat();
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_i = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, n;
    exp_t e;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 32'd0);
    chk("rst_strb_prot", {22'd0, m_axi_wstrb, m_axi_awprot, m_axi_arprot}, 32'd0);
    rst_n = 1;

    // zero-wait write then read-back
    set_dly(0, 0, 0, 0, 0);
    issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    chk("t1_awwvalid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    chk("t1_awaddr", m_axi_awaddr, 32'h10);
    drain();
    chk("slave_word4", smem[4], 32'hDEAD_BEEF);
    issue(0, 32'h0000_0010, 32'h0, 4'h0);
    drain();

    // W accepted two cycles before AW
    set_dly(2, 0, 0, 0, 0);
    issue(1, 32'h0000_0024, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("skew_t1", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    @(negedge clk);
    chk("skew_t2_valid", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd2);
    chk("skew_t2_addr", m_axi_awaddr, 32'h24);
    chk("skew_t2_bready", {31'd0, m_axi_bready}, 32'd0);
    drain();

    // error read then OKAY read
    set_dly(0, 0, 0, 0, 0);
    issue(0, 32'hE000_0004, 32'h0, 4'h0);
    drain();
    issue(0, 32'h0000_0024, 32'h0, 4'h0);
    drain();

    // req held through a write then a read
    d0 = done_cnt;
    @(negedge clk);
    req_i = 1; we_i = 1; addr_i = 32'h8; wdata_i = 32'hCAFE_F00D; wstrb_i = 4'h3;
    e.we = 1; e.addr = 32'h8; e.data = 32'hCAFE_F00D; e.strb = 4'h3;
    e.acc = cyc; e.lat = 3;
    exp_q.push_back(e);
    @(negedge clk);
    we_i = 0; addr_i = 32'h8;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_ready", {31'd0, ready_o}, 32'd1);
    e.we = 0; e.addr = 32'h8; e.data = 32'h0; e.strb = 4'h0;
    e.acc = cyc; e.lat = 3;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_i = 0;
    drain();
    repeat (4) @(negedge clk);
    chk("b2b_pulses", done_cnt - d0, 2);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      n = $urandom_range(0, 9);
      a = (n == 0) ? 32'hE000_0000 : (n == 1) ? 32'hD000_0000 : 32'h0;
      a = a | (32'($urandom_range(0, 15)) << 2);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      drain();
    end

    // reset while waiting for B
    set_dly(0, 0, 5, 0, 0);
    issue(1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (!m_axi_bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wresp", {31'd0, m_axi_bready}, 32'd1);
    d0 = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("arst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                        m_axi_bready, m_axi_rready}, 32'd0);
    chk("arst_ready", {31'd0, ready_o}, 32'd1);
    exp_q.delete();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    set_dly(0, 0, 0, 0, 0);
    issue(0, 32'h0000_0030, 32'h0, 4'h0);
    drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4l_master.md
# axi4l_master

Single-outstanding AXI4-Lite master bridge that turns the core's simple memory request port into AXI4-Lite read and write transactions. It is the initiator counterpart of the block RAM slaves on the system bus, including the instruction RAM's AXI port. It sits between the load/store path and the AXI4-Lite interconnect, and is also used by the debug/loader path to program instruction RAM.

## Interface
- Parameters: none. Address width comes from `MemAddrBus` and data width from `MemBus`, both 32 bits, defined in `defines.v`.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  request strobe from core; accepted when `req_i & ready_o`.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  write data.
- `wstrb_i`  in  4  byte enables for writes.
- `ready_o`  out  1  bridge idle, can accept a request.
- `done_o`  out  1  one-cycle pulse when the transaction completes.
- `rdata_o`  out  32  read data; valid while `done_o` is high and held until the next read completes.
- `err_o`  out  1  valid with `done_o`; 1 if `bresp`/`rresp` is not 2'b00.
- AW channel: `m_axi_awaddr` out 32, `m_axi_awprot` out 3 (constant 0), `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- W channel: `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- B channel: `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- AR channel: `m_axi_araddr` out 32, `m_axi_arprot` out 3 (constant 0), `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- R channel: `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.

## Operation
- States: IDLE, WADDR (AW/W phase), WRESP, RADDR, RDATA.
- IDLE:
  - On accept, latch `addr_i`, `wdata_i` and `wstrb_i`.
  - `we_i=1` goes to WADDR; set `awvalid` and `wvalid` (both registered).
  - `we_i=0` goes to RADDR; set `arvalid`.
- WADDR: AW and W complete independently.
  - Per-channel done flags: `awvalid` clears on `awvalid&awready`, `wvalid` clears on `wvalid&wready`.
  - When both have completed (same or different cycles), go to WRESP.
- WRESP: `bready=1`. On `bvalid`, register `err_o=|bresp`, pulse `done_o`, go to IDLE.
- RADDR: `arvalid` stays high until `arready`, then go to RDATA.
- RDATA: `rready=1`. On `rvalid`, register `rdata_o=rdata` and `err_o=|rresp`, pulse `done_o`, go to IDLE.
- `ready_o = (state==IDLE)`. `req_i` is ignored when not ready; the requester holds it.
- A valid never deasserts, and its address/data never change, before its handshake completes.
- `bready` and `rready` are high only in WRESP and RDATA respectively.
- `bvalid` or `rvalid` arriving in any other state is ignored; a protocol-compliant slave never does this.

## Timing
- Reset values:
  - state IDLE, `ready_o=1`.
  - `done_o`, `err_o`, all valid/ready outputs = 0.
  - `rdata_o`, address/data/strobe outputs = 0.
- Reset asserted mid-transaction drops every valid/ready immediately (asynchronous) and returns to IDLE; no `done_o` is generated.
- Write against a zero-wait slave (ready combinational from valid, `bvalid` registered):
  - T0 accept; T1 AW+W handshake; T2 B handshake; T3 `done_o`.
  - Latency 3 cycles.
- Read against the same slave: T0 accept; T1 AR handshake; T2 R handshake; T3 `done_o`. Latency 3 cycles.
- Back-to-back: in the `done_o` cycle the state is already IDLE, so a new request can be accepted that same cycle. Throughput is one transaction per 3 cycles.
- Wait states: each extra cycle of ready/valid delay from the slave adds exactly one cycle of latency.

## Structure
- State encodings (3 bits) and `RESP_OKAY=2'b00` go in `defines.v`, next to the bus width macros.
- One flat module; no sub-module is warranted. The latched request registers and the FSM live together.

## Test plan
- Write, zero-wait slave: req `we=1`, addr `0x0000_0010`, data `0xDEADBEEF`, strb `4'hF`.
  - AW/W valid at T1; `done_o` at T3 with `err_o=0`; slave memory word 4 = `0xDEADBEEF`.
- Read back the same address: `done_o` at T3, `rdata_o=0xDEADBEEF`, `err_o=0`.
- Skewed handshakes: `wready` 2 cycles before `awready`.
  - `wvalid` drops after its handshake while `awvalid` stays high with a stable address.
  - WRESP is entered only after both handshakes; `done_o` 2 cycles later than in the zero-wait case.
- Error response: slave returns `rresp=2'b10` on a read → `done_o=1`, `err_o=1`.
  - The next OKAY read clears `err_o`.
- Back-to-back with a request during busy:
  - `req_i` held high through a write then a read; the second request is accepted in the first's `done_o` cycle.
  - Exactly two `done_o` pulses, 3 cycles apart.
- Reset mid-write: drop `rst_n` while in WRESP.
  - All valids/readies go to 0 and `ready_o=1` asynchronously; no `done_o`.
  - After release, a new read completes normally.
